config_fifo_slave: RTL and testbench
====================================

// Module: config_fifo_slave
// PURPOSE
//  Slave-side endpoint of the Config bus. Consumes the master's w_en/write_data stream into a
//  DEPTH-entry FIFO and returns entries on r_en via read_data (pop per r_en, 1-cycle latency).
//  Replaces the single-register slave where the master issues bursts of writes ahead of reads.
//  Also exports occupancy and sticky error status for the top-level debug registers.
// PARAMETERS
//  DATA_WIDTH  8  width of write_data/read_data; must match the Config bus.
//  DEPTH       4  FIFO entries; power of two, >= 2.
// PORTS
//  clk         in   1               bus clock; all state on posedge.
//  rst         in   1               synchronous reset, active-high.
//  w_en        in   1               push write_data this cycle.
//  write_data  in   DATA_WIDTH      data to push.
//  r_en        in   1               pop head this cycle.
//  read_data   out  DATA_WIDTH      popped value, valid the cycle after an accepted r_en; held otherwise.
//  rd_valid    out  1               1 for exactly the cycle read_data carries a newly popped value.
//  full        out  1               count == DEPTH.
//  empty       out  1               count == 0.
//  count       out  $clog2(DEPTH)+1 current occupancy.
//  overflow    out  1               sticky: a write was dropped because FIFO was full.
//  underflow   out  1               sticky: a read was refused because FIFO was empty.
//  clr_err     in   1               clears overflow/underflow on the next edge.
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, read_data=0, rd_valid=0, overflow=0,
//    underflow=0; empty=1, full=0. Storage contents are not reset. Mid-burst reset drops all entries.
//  - Push accepted iff w_en && (!full || pop accepted same cycle). Pop accepted iff r_en && !empty.
//  - Accepted push: mem[wr_ptr] <= write_data; wr_ptr wraps DEPTH-1 -> 0.
//  - Accepted pop: read_data <= mem[rd_ptr]; rd_valid <= 1; rd_ptr wraps DEPTH-1 -> 0.
//    No pop: read_data holds, rd_valid <= 0.
//  - count <= count + push - pop; full/empty are combinational from count.
//  - Simultaneous r_en && w_en:
//    * not empty, not full: both accepted, count unchanged.
//    * full: pop and push both accepted (push writes the slot freed by the pop), count stays DEPTH.
//    * empty: no bypass. Pop refused, underflow set, push accepted, count -> 1.
//  - w_en while full with no accepted pop: data dropped, overflow <= 1, no pointer change.
//  - r_en while empty: underflow <= 1, read_data holds, rd_valid 0.
//  - clr_err: overflow/underflow <= 0. If a new error occurs in the same cycle, the set wins.
//  - Latency: write-to-readable 1 cycle (a pop issued the cycle after the push returns that data).
//    r_en-to-read_data 1 cycle.
// STRUCTURE
//  - config_pkg: DATA_WIDTH default constant, typedef data_t; ptr/count widths come from DEPTH.
//  - Sub-module config_fifo_mem: DEPTH x DATA_WIDTH register array, one write port and
//    one registered read port. Pointers, count and flags stay in config_fifo_slave.
// TESTING (DATA_WIDTH=8, DEPTH=4)
//  1. Reset, then push 0x11,0x22,0x33 on 3 cycles, then r_en x3 -> read_data 0x11,0x22,0x33,
//     each with rd_valid=1 one cycle after its r_en; count 3->0; empty=1 at the end.
//  2. Push 0xA0..0xA4 (5 writes) -> full=1 after the 4th; 5th dropped, overflow=1;
//     4 pops return 0xA0..0xA3.
//  3. r_en while empty -> underflow=1, rd_valid=0, read_data unchanged.
//     Assert clr_err -> underflow=0 next cycle.
//  4. Fill with 1..4, then r_en&&w_en with 0x55 -> read_data=1, count stays 4, no overflow;
//     drain returns 2,3,4,0x55 (exercises pointer wrap).
//  5. Empty, r_en&&w_en with 0x77 -> underflow=1, count=1; next pop returns 0x77.
//  6. Push 2 entries, assert rst mid-stream -> count=0, empty=1, read_data=0, flags 0;
//     next pop sets underflow.

Source files
------------

// File: rtl/config_pkg.sv
// Shared constants and types for the Config bus FIFO slave.
package config_pkg;
    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF      = 4;

    typedef logic [DATA_WIDTH_DEF-1:0] data_t;
endpackage

// File: rtl/config_fifo_mem.sv
// DEPTH x DATA_WIDTH register array with one write port and one registered read port.
module config_fifo_mem
    import config_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]   i_wr_addr,
    input  logic [DATA_WIDTH-1:0]      i_wr_data,
    input  logic                       i_rd_en,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_addr,
    output logic [DATA_WIDTH-1:0]      o_rd_data
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/config_fifo_slave.sv
// Config bus slave endpoint: write stream into a FIFO, pop on r_en with 1-cycle read latency,
// plus occupancy and sticky overflow/underflow status.
module config_fifo_slave
    import config_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_en,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     r_en,
    output logic [DATA_WIDTH-1:0]    read_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_rd_valid, r_overflow, r_underflow;

    logic          w_full, w_empty, w_push, w_pop, w_ovf_set, w_unf_set;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop     = r_en && !w_empty;
    // A pop in the same cycle frees the slot the push lands in when full.
    assign w_push    = w_en && (!w_full || w_pop);
    assign w_ovf_set = w_en && !w_push;
    assign w_unf_set = r_en && w_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= r_count + CW'(w_push) - CW'(w_pop);
            r_rd_valid <= w_pop;
            if (w_ovf_set)    r_overflow <= 1'b1;
            else if (clr_err) r_overflow <= 1'b0;
            if (w_unf_set)    r_underflow <= 1'b1;
            else if (clr_err) r_underflow <= 1'b0;
        end
    end

    config_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (write_data),
        .i_rd_en   (w_pop),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (read_data)
    );

    assign rd_valid  = r_rd_valid;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
endmodule

// File: tb/tb_config_fifo_slave.sv
// Directed vector bench for config_fifo_slave (DATA_WIDTH=8, DEPTH=4).
module tb_config_fifo_slave;
    import config_pkg::*;

    logic       clk = 1'b0;
    logic       rst, w_en, r_en, clr_err;
    data_t      write_data, read_data;
    logic       rd_valid, full, empty, overflow, underflow;
    logic [2:0] count;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       rst;
        logic       w_en;
        logic [7:0] wd;
        logic       r_en;
        logic       clr;
        logic [7:0] rd;
        logic       rv;
        logic [2:0] cnt;
        logic       ful;
        logic       emp;
        logic       ov;
        logic       un;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    config_fifo_slave #(
        .DATA_WIDTH (8),
        .DEPTH      (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .w_en       (w_en),
        .write_data (write_data),
        .r_en       (r_en),
        .read_data  (read_data),
        .rd_valid   (rd_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow),
        .clr_err    (clr_err)
    );

    function automatic vec_t mk(input logic r, input logic w, input logic [7:0] wd,
                                input logic re, input logic c, input logic [7:0] rd,
                                input logic rv, input logic [2:0] cnt, input logic ful,
                                input logic emp, input logic ov, input logic un);
        vec_t v;
        v.rst = r;  v.w_en = w;  v.wd = wd;  v.r_en = re; v.clr = c;
        v.rd = rd;  v.rv = rv;   v.cnt = cnt; v.ful = ful; v.emp = emp; v.ov = ov; v.un = un;
        return v;
    endfunction

    // Drive one cycle of inputs, then compare all outputs 1 time unit after the edge.
    task automatic apply(input vec_t v, input string name);
        logic [15:0] act, exp;
        rst = v.rst; w_en = v.w_en; write_data = v.wd; r_en = v.r_en; clr_err = v.clr;
        @(posedge clk);
        #1;
        act = {read_data, rd_valid, count, full, empty, overflow, underflow};
        exp = {v.rd, v.rv, v.cnt, v.ful, v.emp, v.ov, v.un};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got rd=%h rv=%b cnt=%0d full=%b empty=%b ovf=%b unf=%b, want rd=%h rv=%b cnt=%0d full=%b empty=%b ovf=%b unf=%b",
                     name, read_data, rd_valid, count, full, empty, overflow, underflow,
                     v.rd, v.rv, v.cnt, v.ful, v.emp, v.ov, v.un);
        end
    endtask

    initial begin
        rst = 1'b1; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; write_data = '0;

        //                 rst w  wd    r  clr  rd    rv cnt fu em ov un
        // Basic push x3 / pop x3
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h11, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h22, 0, 0, 8'h00, 0, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h33, 0, 0, 8'h00, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h11, 1, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h22, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h33, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h33, 0, 0, 0, 1, 0, 0));
        // Overfill: fifth write dropped
        vecs.push_back(mk(0, 1, 8'hA0, 0, 0, 8'h33, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA1, 0, 0, 8'h33, 0, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA2, 0, 0, 8'h33, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA3, 0, 0, 8'h33, 0, 4, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA4, 0, 0, 8'h33, 0, 4, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'hA0, 1, 3, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'hA1, 1, 2, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'hA2, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'hA3, 1, 0, 0, 1, 1, 0));
        // Read while empty, then clear errors
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'hA3, 0, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'hA3, 0, 0, 0, 1, 0, 0));
        // Fill 1..4, simultaneous r/w while full, drain across pointer wrap
        vecs.push_back(mk(0, 1, 8'h01, 0, 0, 8'hA3, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h02, 0, 0, 8'hA3, 0, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h03, 0, 0, 8'hA3, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h04, 0, 0, 8'hA3, 0, 4, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h55, 1, 0, 8'h01, 1, 4, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h02, 1, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h03, 1, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h04, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h55, 1, 0, 0, 1, 0, 0));
        // Simultaneous r/w on empty: no bypass
        vecs.push_back(mk(0, 1, 8'h77, 1, 0, 8'h55, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h77, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'h77, 0, 0, 0, 1, 0, 0));
        // Mid-stream reset drops entries
        vecs.push_back(mk(0, 1, 8'h88, 0, 0, 8'h77, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h99, 0, 0, 8'h77, 0, 2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 8'hAA, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 8'hBB, 0, 0, 8'h00, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'hBB, 1, 0, 0, 1, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Hand sequence: a new error in the same cycle as clr_err keeps the flag set.
        apply(mk(0, 0, 8'h00, 1, 1, 8'hBB, 0, 0, 0, 1, 0, 1), "clr_vs_unf_set");
        apply(mk(0, 0, 8'h00, 0, 1, 8'hBB, 0, 0, 0, 1, 0, 0), "clr_unf");
        for (int i = 0; i < 4; i++) begin
            apply(mk(0, 1, 8'hC0 + 8'(i), 0, 0, 8'hBB, 0, 3'(i + 1), (i == 3), 0, 0, 0),
                  $sformatf("fill_c%0d", i));
        end
        apply(mk(0, 1, 8'hCF, 0, 1, 8'hBB, 0, 4, 1, 0, 1, 0), "clr_vs_ovf_set");
        apply(mk(0, 0, 8'h00, 0, 0, 8'hBB, 0, 4, 1, 0, 1, 0), "ovf_sticky");
        apply(mk(0, 0, 8'h00, 1, 1, 8'hC0, 1, 3, 0, 0, 0, 0), "pop_with_clr");
        apply(mk(0, 0, 8'h00, 0, 0, 8'hC0, 0, 3, 0, 0, 0, 0), "read_hold");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
